// File: rtl/worstrisc_pkg.sv
// Shared constants and types for the writeback scheduler slice.
package worstrisc_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned REG_SEL_W = 5;
  localparam logic [REG_SEL_W-1:0] REG_ZERO = REG_SEL_W'(0);

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_LSU = 1'b1
  } req_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: combinational grant, pointer moves to the loser.
module rr_arbiter2
  import worstrisc_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic req_alu_i,
  input  logic req_lsu_i,
  output logic gnt_alu_c,
  output logic gnt_lsu_c
);

  req_e ptr_q, ptr_d;

  always_comb begin
    gnt_alu_c = 1'b0;
    gnt_lsu_c = 1'b0;
    ptr_d     = ptr_q;
    if (req_alu_i && req_lsu_i) begin
      if (ptr_q == REQ_ALU) gnt_alu_c = 1'b1;
      else                  gnt_lsu_c = 1'b1;
    end else begin
      gnt_alu_c = req_alu_i;
      gnt_lsu_c = req_lsu_i;
    end
    if (gnt_alu_c)      ptr_d = REQ_LSU;
    else if (gnt_lsu_c) ptr_d = REQ_ALU;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) ptr_q <= REQ_ALU;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Register-file write-port scheduler with busy scoreboard for issue hazards.
// Define WB_BYPASS_EN to forward the write-stage value to the source queries.
module regfile_wb_scheduler
  import worstrisc_pkg::*;
#(
  parameter int unsigned XLEN  = worstrisc_pkg::XLEN,
  parameter int unsigned NREGS = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 mark_valid_i,
  input  logic [REG_SEL_W-1:0] mark_rd_i,
  output logic                 mark_ready_o,
  input  logic                 alu_valid_i,
  input  logic [REG_SEL_W-1:0] alu_rd_i,
  input  logic [XLEN-1:0]      alu_data_i,
  output logic                 alu_ready_o,
  input  logic                 lsu_valid_i,
  input  logic [REG_SEL_W-1:0] lsu_rd_i,
  input  logic [XLEN-1:0]      lsu_data_i,
  output logic                 lsu_ready_o,
  input  logic [REG_SEL_W-1:0] rs1_sel_i,
  input  logic [REG_SEL_W-1:0] rs2_sel_i,
  output logic                 rs1_busy_o,
  output logic                 rs2_busy_o,
`ifdef WB_BYPASS_EN
  output logic                 rs1_fwd_o,
  output logic                 rs2_fwd_o,
  output logic [XLEN-1:0]      fwd_data_o,
`endif
  output logic [REG_SEL_W-1:0] rf_sel_rd_o,
  output logic [XLEN-1:0]      rf_rd_o
);

  localparam int unsigned SEL_W = $clog2(NREGS);

  logic                 gnt_alu_c, gnt_lsu_c;
  logic [REG_SEL_W-1:0] sel_d, sel_q;
  logic [XLEN-1:0]      data_d, data_q;
  logic [NREGS-1:0]     busy_d, busy_q;
  logic                 rs1_pend_c, rs2_pend_c;

  rr_arbiter2 u_arb (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_alu_i (alu_valid_i),
    .req_lsu_i (lsu_valid_i),
    .gnt_alu_c (gnt_alu_c),
    .gnt_lsu_c (gnt_lsu_c)
  );

  assign alu_ready_o  = gnt_alu_c;
  assign lsu_ready_o  = gnt_lsu_c;
  assign mark_ready_o = !busy_q[mark_rd_i[SEL_W-1:0]] || (mark_rd_i == REG_ZERO);

  // Write stage: select drops to x0 on an idle cycle, data is held.
  always_comb begin
    sel_d  = REG_ZERO;
    data_d = data_q;
    if (gnt_alu_c) begin
      sel_d  = alu_rd_i;
      data_d = alu_data_i;
    end else if (gnt_lsu_c) begin
      sel_d  = lsu_rd_i;
      data_d = lsu_data_i;
    end
  end

  // Retire clears first; a same-register mark is already refused via mark_ready_o.
  always_comb begin
    busy_d = busy_q;
    if (sel_q != REG_ZERO) busy_d[sel_q[SEL_W-1:0]] = 1'b0;
    if (mark_valid_i && mark_ready_o && (mark_rd_i != REG_ZERO))
      busy_d[mark_rd_i[SEL_W-1:0]] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      busy_q <= '0;
      sel_q  <= REG_ZERO;
      data_q <= '0;
    end else begin
      busy_q <= busy_d;
      sel_q  <= sel_d;
      data_q <= data_d;
    end
  end

  assign rf_sel_rd_o = sel_q;
  assign rf_rd_o     = data_q;
  assign rs1_pend_c  = busy_q[rs1_sel_i[SEL_W-1:0]] && (rs1_sel_i != REG_ZERO);
  assign rs2_pend_c  = busy_q[rs2_sel_i[SEL_W-1:0]] && (rs2_sel_i != REG_ZERO);

`ifdef WB_BYPASS_EN
  // A source matching the in-flight write takes the forwarded value instead of stalling.
  assign rs1_fwd_o  = (sel_q != REG_ZERO) && (sel_q == rs1_sel_i);
  assign rs2_fwd_o  = (sel_q != REG_ZERO) && (sel_q == rs2_sel_i);
  assign fwd_data_o = data_q;
  assign rs1_busy_o = rs1_pend_c && !rs1_fwd_o;
  assign rs2_busy_o = rs2_pend_c && !rs2_fwd_o;
`else
  assign rs1_busy_o = rs1_pend_c;
  assign rs2_busy_o = rs2_pend_c;
`endif

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler: vector table plus reset and retire/mark sequences.
module tb_regfile_wb_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mark_valid;
  logic [4:0]  mark_rd;
  logic        mark_ready;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        lsu_valid;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        lsu_ready;
  logic [4:0]  rs1_sel, rs2_sel;
  logic        rs1_busy, rs2_busy;
  logic [4:0]  rf_sel;
  logic [31:0] rf_rd;
`ifdef WB_BYPASS_EN
  logic        rs1_fwd, rs2_fwd;
  logic [31:0] fwd_data;
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  regfile_wb_scheduler dut (
    .clk_i        (clk),
    .rst_i        (rst_n),
    .mark_valid_i (mark_valid),
    .mark_rd_i    (mark_rd),
    .mark_ready_o (mark_ready),
    .alu_valid_i  (alu_valid),
    .alu_rd_i     (alu_rd),
    .alu_data_i   (alu_data),
    .alu_ready_o  (alu_ready),
    .lsu_valid_i  (lsu_valid),
    .lsu_rd_i     (lsu_rd),
    .lsu_data_i   (lsu_data),
    .lsu_ready_o  (lsu_ready),
    .rs1_sel_i    (rs1_sel),
    .rs2_sel_i    (rs2_sel),
    .rs1_busy_o   (rs1_busy),
    .rs2_busy_o   (rs2_busy),
`ifdef WB_BYPASS_EN
    .rs1_fwd_o    (rs1_fwd),
    .rs2_fwd_o    (rs2_fwd),
    .fwd_data_o   (fwd_data),
`endif
    .rf_sel_rd_o  (rf_sel),
    .rf_rd_o      (rf_rd)
  );

  typedef struct {
    logic        mv;   logic [4:0] mrd;
    logic        av;   logic [4:0] ard; logic [31:0] ad;
    logic        lv;   logic [4:0] lrd; logic [31:0] ld;
    logic [4:0]  s1;   logic [4:0] s2;
    logic        e_mr; logic e_ar; logic e_lr; logic e_b1; logic e_b2;
    logic [4:0]  e_sel; logic [31:0] e_rd;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mark_valid = 1'b0; mark_rd = 5'd0;
    alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
    lsu_valid = 1'b0; lsu_rd = 5'd0; lsu_data = 32'd0;
    rs1_sel = 5'd0; rs2_sel = 5'd0;
  endtask

  initial begin
    //        mv  mrd    av  ard    ad            lv  lrd    ld            s1     s2     mr ar lr b1 b2 sel    rd
    vecs[0]  = '{1'b0,5'd0, 1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,        5'd5,5'd0, 1'b1,1'b0,1'b0,1'b0,1'b0, 5'd0,32'h0};
    vecs[1]  = '{1'b1,5'd5, 1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,        5'd5,5'd0, 1'b1,1'b0,1'b0,1'b0,1'b0, 5'd0,32'h0};
    vecs[2]  = '{1'b1,5'd5, 1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,        5'd5,5'd0, 1'b0,1'b0,1'b0,1'b1,1'b0, 5'd0,32'h0};
    vecs[3]  = '{1'b0,5'd5, 1'b1,5'd5,32'hDEADBEEF, 1'b0,5'd0,32'h0,        5'd5,5'd0, 1'b0,1'b1,1'b0,1'b1,1'b0, 5'd0,32'h0};
    vecs[4]  = '{1'b0,5'd0, 1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,        5'd0,5'd0, 1'b1,1'b0,1'b0,1'b0,1'b0, 5'd5,32'hDEADBEEF};
    vecs[5]  = '{1'b0,5'd5, 1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,        5'd5,5'd0, 1'b1,1'b0,1'b0,1'b0,1'b0, 5'd0,32'hDEADBEEF};
    vecs[6]  = '{1'b1,5'd1, 1'b0,5'd0,32'h0,        1'b1,5'd0,32'h12345678, 5'd0,5'd0, 1'b1,1'b0,1'b1,1'b0,1'b0, 5'd0,32'hDEADBEEF};
    vecs[7]  = '{1'b1,5'd2, 1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,        5'd0,5'd1, 1'b1,1'b0,1'b0,1'b0,1'b1, 5'd0,32'h12345678};
    vecs[8]  = '{1'b1,5'd0, 1'b1,5'd1,32'hA1A1A1A1, 1'b1,5'd2,32'hB2B2B2B2, 5'd2,5'd0, 1'b1,1'b1,1'b0,1'b1,1'b0, 5'd0,32'h12345678};
    vecs[9]  = '{1'b0,5'd0, 1'b1,5'd1,32'hA2A2A2A2, 1'b1,5'd2,32'hB2B2B2B2, 5'd0,5'd0, 1'b1,1'b0,1'b1,1'b0,1'b0, 5'd1,32'hA1A1A1A1};
    vecs[10] = '{1'b0,5'd0, 1'b1,5'd1,32'hA2A2A2A2, 1'b1,5'd2,32'hB3B3B3B3, 5'd0,5'd0, 1'b1,1'b1,1'b0,1'b0,1'b0, 5'd2,32'hB2B2B2B2};
    vecs[11] = '{1'b0,5'd0, 1'b0,5'd0,32'h0,        1'b1,5'd2,32'hB3B3B3B3, 5'd0,5'd0, 1'b1,1'b0,1'b1,1'b0,1'b0, 5'd1,32'hA2A2A2A2};
    vecs[12] = '{1'b0,5'd0, 1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,        5'd0,5'd0, 1'b1,1'b0,1'b0,1'b0,1'b0, 5'd2,32'hB3B3B3B3};
    vecs[13] = '{1'b0,5'd0, 1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,        5'd1,5'd2, 1'b1,1'b0,1'b0,1'b0,1'b0, 5'd0,32'hB3B3B3B3};

    rst_n = 1'b0;
    idle_inputs();
    #12 rst_n = 1'b1;
    next_cycle();

    for (int i = 0; i < NV; i++) begin
      mark_valid = vecs[i].mv;  mark_rd = vecs[i].mrd;
      alu_valid  = vecs[i].av;  alu_rd  = vecs[i].ard; alu_data = vecs[i].ad;
      lsu_valid  = vecs[i].lv;  lsu_rd  = vecs[i].lrd; lsu_data = vecs[i].ld;
      rs1_sel    = vecs[i].s1;  rs2_sel = vecs[i].s2;
      @(negedge clk);
      chk($sformatf("v%0d mark_ready", i), 32'(mark_ready), 32'(vecs[i].e_mr));
      chk($sformatf("v%0d alu_ready", i),  32'(alu_ready),  32'(vecs[i].e_ar));
      chk($sformatf("v%0d lsu_ready", i),  32'(lsu_ready),  32'(vecs[i].e_lr));
      chk($sformatf("v%0d rs1_busy", i),   32'(rs1_busy),   32'(vecs[i].e_b1));
      chk($sformatf("v%0d rs2_busy", i),   32'(rs2_busy),   32'(vecs[i].e_b2));
      chk($sformatf("v%0d rf_sel", i),     32'(rf_sel),     32'(vecs[i].e_sel));
      chk($sformatf("v%0d rf_rd", i),      rf_rd,           vecs[i].e_rd);
      next_cycle();
    end

    // Reset while x7 is busy and its write sits in the write stage; pointer is at LSU.
    idle_inputs();
    mark_valid = 1'b1; mark_rd = 5'd7;
    next_cycle();
    mark_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77777777;
    next_cycle();
    alu_valid = 1'b0;
    rs1_sel = 5'd7;
    @(negedge clk);
    chk("pre_rst rf_sel", 32'(rf_sel), 32'd7);
    rst_n = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33333333;
    lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h44444444;
    #1;
    chk("rst rf_sel", 32'(rf_sel), 32'd0);
    chk("rst rf_rd", rf_rd, 32'd0);
    chk("rst rs1_busy x7", 32'(rs1_busy), 32'd0);
    chk("rst tie alu_ready", 32'(alu_ready), 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    chk("post_rst alu_ready", 32'(alu_ready), 32'd1);
    chk("post_rst lsu_ready", 32'(lsu_ready), 32'd0);
    next_cycle();
    alu_valid = 1'b0;
    @(negedge clk);
    chk("post_rst rf_sel", 32'(rf_sel), 32'd3);
    chk("post_rst rf_rd", rf_rd, 32'h33333333);
    chk("post_rst lsu_ready", 32'(lsu_ready), 32'd1);
    next_cycle();

    // Mark of x9 in its retire cycle is refused, then accepted one cycle later.
    idle_inputs();
    mark_valid = 1'b1; mark_rd = 5'd9;
    @(negedge clk);
    chk("x9 first mark_ready", 32'(mark_ready), 32'd1);
    next_cycle();
    mark_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h0BADF00D;
    @(negedge clk);
    chk("x9 alu_ready", 32'(alu_ready), 32'd1);
    next_cycle();
    alu_valid = 1'b0;
    mark_valid = 1'b1; mark_rd = 5'd9;
    rs2_sel = 5'd9;
    @(negedge clk);
    chk("x9 ws rf_sel", 32'(rf_sel), 32'd9);
    chk("x9 ws rf_rd", rf_rd, 32'h0BADF00D);
    chk("x9 retire mark_ready", 32'(mark_ready), 32'd0);
    chk("x9 ws rs2_busy", 32'(rs2_busy), BYP ? 32'd0 : 32'd1);
`ifdef WB_BYPASS_EN
    chk("x9 ws rs2_fwd", 32'(rs2_fwd), 32'd1);
    chk("x9 ws rs1_fwd", 32'(rs1_fwd), 32'd0);
    chk("x9 ws fwd_data", fwd_data, 32'h0BADF00D);
`endif
    next_cycle();
    @(negedge clk);
    chk("x9 remark mark_ready", 32'(mark_ready), 32'd1);
    chk("x9 after retire rs2_busy", 32'(rs2_busy), 32'd0);
    next_cycle();
    mark_valid = 1'b0;
    rs1_sel = 5'd9;
    @(negedge clk);
    chk("x9 remarked rs1_busy", 32'(rs1_busy), 32'd1);
    chk("x9 remarked rs2_busy", 32'(rs2_busy), 32'd1);
    chk("x9 remarked rf_sel", 32'(rf_sel), 32'd0);
`ifdef WB_BYPASS_EN
    chk("x9 remarked rs2_fwd", 32'(rs2_fwd), 32'd0);
`endif
    next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
